// File: rtl/ctrl_pkg.sv
// Shared control-unit types: FSM states, opcodes and ALU select codes.
// Also used by the ALU bench, so keep encodings stable.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_EXEC   = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5,
        OP_XOR   = 4'd6,
        OP_OR    = 4'd7,
        OP_AND   = 4'd8,
        OP_INC   = 4'd9,
        OP_MOV   = 4'd10
    } opcode_t;

    localparam logic [2:0] ALU_ZERO = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_PASS = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_OR   = 3'd5;
    localparam logic [2:0] ALU_AND  = 3'd6;
    localparam logic [2:0] ALU_INC  = 3'd7;

    // ALU select for an opcode; non-ALU opcodes map to zero.
    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        logic [2:0] s;
        s = ALU_ZERO;
        case (op)
            OP_ADD:  s = ALU_ADD;
            OP_SUB:  s = ALU_SUB;
            OP_XOR:  s = ALU_XOR;
            OP_OR:   s = ALU_OR;
            OP_AND:  s = ALU_AND;
            OP_INC:  s = ALU_INC;
            OP_MOV:  s = ALU_PASS;
            default: s = ALU_ZERO;
        endcase
        return s;
    endfunction

    // True for opcodes that go through EXEC.
    function automatic logic is_alu(input logic [3:0] op);
        return alu_sel(op) != ALU_ZERO;
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous clear, increment on Up, wraps at 2^W.
// Async active-high reset to zero.
module pc_counter #(
    parameter int W = 7
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Clr,
    input  logic         Up,
    output logic [W-1:0] Pc
);

    // Clear has priority over increment; natural width overflow wraps.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            Pc <= '0;
        else if (Clr)
            Pc <= '0;
        else if (Up)
            Pc <= Pc + W'(1);
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: IR, state machine and Moore output decode.
// Optional CTRL_SINGLE_STEP_EN adds a Step input that gates FETCH.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic            Clk,
    input  logic            Reset,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic            Step,
`endif
    input  logic [15:0]     IR_In,
    output logic [PC_W-1:0] PC_Addr,
    output logic [7:0]      D_Addr,
    output logic            D_Wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_Addr,
    output logic [3:0]      RF_Ra_Addr,
    output logic [3:0]      RF_Rb_Addr,
    output logic            RF_W_En,
    output logic [2:0]      ALU_s0,
    output logic            Halted,
    output logic [3:0]      State
);

    state_t      st;
    logic [15:0] ir;
    logic        go;
    logic [3:0]  op;

`ifdef CTRL_SINGLE_STEP_EN
    assign go = Step;
`else
    assign go = 1'b1;
`endif

    assign op = ir[15:12];

    pc_counter #(.W(PC_W)) u_pc (
        .Clk   (Clk),
        .Reset (Reset),
        .Clr   (st == S_INIT),
        .Up    ((st == S_FETCH) && go),
        .Pc    (PC_Addr)
    );

    // State sequencing and instruction register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            st <= S_INIT;
            ir <= '0;
        end else begin
            case (st)
                S_INIT: begin
                    ir <= '0;
                    st <= S_FETCH;
                end
                S_FETCH: begin
                    if (go) begin
                        ir <= IR_In;
                        st <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (op == OP_STORE)
                        st <= S_STORE;
                    else if (op == OP_LOAD)
                        st <= S_LOAD_A;
                    else if (op == OP_HALT)
                        st <= S_HALT;
                    else if (is_alu(op))
                        st <= S_EXEC;
                    else
                        st <= S_NOOP;
                end
                S_LOAD_A: st <= S_LOAD_B;
                S_NOOP,
                S_STORE,
                S_LOAD_B,
                S_EXEC:   st <= S_FETCH;
                S_HALT:   st <= S_HALT;
                default:  st <= S_INIT;
            endcase
        end
    end

    // Moore output decode from current state and IR.
    always_comb begin
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = '0;
        RF_Ra_Addr = '0;
        RF_Rb_Addr = '0;
        RF_W_En    = 1'b0;
        ALU_s0     = ALU_ZERO;
        case (st)
            S_STORE: begin
                D_Wr       = 1'b1;
                D_Addr     = ir[11:4];
                RF_Ra_Addr = ir[3:0];
            end
            S_LOAD_A: begin
                D_Addr = ir[11:4];
            end
            S_LOAD_B: begin
                D_Addr    = ir[11:4];
                RF_s      = 1'b1;
                RF_W_En   = 1'b1;
                RF_W_Addr = ir[3:0];
            end
            S_EXEC: begin
                RF_Ra_Addr = ir[11:8];
                RF_Rb_Addr = ir[7:4];
                ALU_s0     = alu_sel(op);
                RF_W_En    = 1'b1;
                RF_W_Addr  = ir[3:0];
            end
            default: ;
        endcase
    end

    assign Halted = (st == S_HALT);
    assign State  = st;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: load/alu/store/noop/halt paths,
// PC wrap and reset during LOAD_B.
module tb_control_unit;

    localparam int PC_W = 7;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic [15:0]     IR_In;
    logic [PC_W-1:0] PC_Addr;
    logic [7:0]      D_Addr;
    logic            D_Wr;
    logic            RF_s;
    logic [3:0]      RF_W_Addr;
    logic [3:0]      RF_Ra_Addr;
    logic [3:0]      RF_Rb_Addr;
    logic            RF_W_En;
    logic [2:0]      ALU_s0;
    logic            Halted;
    logic [3:0]      State;

    logic [15:0] imem [128];
    int passed = 0;
    int total  = 0;

    localparam logic [3:0] ST_INIT   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_NOOP   = 4'd3;
    localparam logic [3:0] ST_LOAD_A = 4'd4;
    localparam logic [3:0] ST_LOAD_B = 4'd5;
    localparam logic [3:0] ST_STORE  = 4'd6;
    localparam logic [3:0] ST_EXEC   = 4'd7;
    localparam logic [3:0] ST_HALT   = 4'd8;

    always #5 Clk = ~Clk;

    assign IR_In = imem[PC_Addr];

    control_unit #(.PC_W(PC_W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IR_In      (IR_In),
        .PC_Addr    (PC_Addr),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_Addr  (RF_W_Addr),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .RF_W_En    (RF_W_En),
        .ALU_s0     (ALU_s0),
        .Halted     (Halted),
        .State      (State)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Opcode, expected ALU select for the ALU-op sweep.
    logic [15:0] alu_ir  [6];
    logic [2:0]  alu_exp [6];

    initial begin
        alu_ir[0] = 16'h4321; alu_exp[0] = 3'd2;
        alu_ir[1] = 16'h6456; alu_exp[1] = 3'd4;
        alu_ir[2] = 16'h7789; alu_exp[2] = 3'd5;
        alu_ir[3] = 16'h8ABC; alu_exp[3] = 3'd6;
        alu_ir[4] = 16'h9D0E; alu_exp[4] = 3'd7;
        alu_ir[5] = 16'hA40F; alu_exp[5] = 3'd3;

        for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
        imem[0] = 16'h2A03;
        imem[1] = 16'h3125;
        imem[2] = 16'h1F07;
        imem[3] = 16'hF000;
        for (int i = 0; i < 6; i++) imem[4+i] = alu_ir[i];
        imem[10] = 16'h5000;

        // Reset state
        tick();
        chk("rst_state", State, ST_INIT);
        chk("rst_pc", PC_Addr, 0);
        chk("rst_dwr", D_Wr, 0);
        chk("rst_wen", RF_W_En, 0);
        chk("rst_halt", Halted, 0);
        Reset = 1'b0;

        // LOAD 0xA0 -> R3
        tick();
        chk("ld_fetch", State, ST_FETCH);
        chk("ld_fetch_pc", PC_Addr, 0);
        tick();
        chk("ld_decode", State, ST_DECODE);
        chk("ld_pc1", PC_Addr, 1);
        tick();
        chk("ld_a", State, ST_LOAD_A);
        chk("ld_a_addr", D_Addr, 8'hA0);
        chk("ld_a_wen", RF_W_En, 0);
        tick();
        chk("ld_b", State, ST_LOAD_B);
        chk("ld_b_wen", RF_W_En, 1);
        chk("ld_b_s", RF_s, 1);
        chk("ld_b_wa", RF_W_Addr, 3);
        chk("ld_b_addr", D_Addr, 8'hA0);
        chk("ld_b_pc", PC_Addr, 1);

        // ADD R1+R2 -> R5
        tick();
        chk("add_fetch", State, ST_FETCH);
        tick();
        tick();
        chk("add_exec", State, ST_EXEC);
        chk("add_sel", ALU_s0, 1);
        chk("add_ra", RF_Ra_Addr, 1);
        chk("add_rb", RF_Rb_Addr, 2);
        chk("add_wa", RF_W_Addr, 5);
        chk("add_s", RF_s, 0);
        chk("add_wen", RF_W_En, 1);

        // STORE R7 -> 0xF0, one-cycle strobe
        tick();
        chk("st_fetch_dwr", D_Wr, 0);
        tick();
        chk("st_decode_dwr", D_Wr, 0);
        tick();
        chk("st_state", State, ST_STORE);
        chk("st_dwr", D_Wr, 1);
        chk("st_addr", D_Addr, 8'hF0);
        chk("st_ra", RF_Ra_Addr, 7);
        chk("st_wen", RF_W_En, 0);
        tick();
        chk("st_dwr_drop", D_Wr, 0);
        chk("st_back", State, ST_FETCH);

        // Opcode 15 behaves as NOOP
        tick();
        tick();
        chk("nop15_state", State, ST_NOOP);
        chk("nop15_strobes", {D_Wr, RF_W_En, RF_s, ALU_s0}, 0);
        tick();
        chk("nop15_pc", PC_Addr, 4);

        // Remaining ALU ops
        for (int i = 0; i < 6; i++) begin
            tick();
            tick();
            chk("alu_state", State, ST_EXEC);
            chk("alu_sel", ALU_s0, alu_exp[i]);
            chk("alu_ra", RF_Ra_Addr, alu_ir[i][11:8]);
            chk("alu_rb", RF_Rb_Addr, alu_ir[i][7:4]);
            chk("alu_wa", RF_W_Addr, alu_ir[i][3:0]);
            tick();
        end

        // HALT is absorbing
        chk("halt_fetch_pc", PC_Addr, 10);
        tick();
        tick();
        chk("halt_state", State, ST_HALT);
        chk("halt_flag", Halted, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_hold", {Halted, State}, {1'b1, ST_HALT});
        end
        chk("halt_pc_hold", PC_Addr, 11);
        Reset = 1'b1;
        #1;
        chk("halt_rst_state", State, ST_INIT);
        chk("halt_rst_pc", PC_Addr, 0);
        chk("halt_rst_flag", Halted, 0);
        tick();
        Reset = 1'b0;

        // 128 NOOP fetches: PC wraps 127 -> 0
        for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
        tick();
        chk("wrap_first_fetch", State, ST_FETCH);
        for (int i = 0; i < 127; i++) begin
            tick();
            tick();
            tick();
        end
        chk("wrap_pc127", PC_Addr, 127);
        chk("wrap_state", State, ST_FETCH);
        tick();
        chk("wrap_pc0", PC_Addr, 0);

        // Reset during LOAD_B
        imem[0] = 16'h2A03;
        do_reset();
        tick();
        chk("ldrst_fetch", State, ST_FETCH);
        tick();
        tick();
        tick();
        chk("ldrst_b", State, ST_LOAD_B);
        chk("ldrst_wen_pre", RF_W_En, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("ldrst_wen", RF_W_En, 0);
        chk("ldrst_state", State, ST_INIT);
        chk("ldrst_pc", PC_Addr, 0);
        tick();
        Reset = 1'b0;
        tick();
        chk("ldrst_refetch", State, ST_FETCH);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports Clk and Reset.
REQ-002 Parameter PC_W SHALL default to 7 and set the program-counter width.
REQ-003 The block SHALL have port Clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port IR_In, input, 16 bits: instruction-memory read data at PC_Addr (combinational read).
REQ-006 The block SHALL have port PC_Addr, output, PC_W bits: instruction address.
REQ-007 The block SHALL have port D_Addr, output, 8 bits: data-memory address.
REQ-008 The block SHALL have port D_Wr, output, 1 bit: data-memory write strobe.
REQ-009 The block SHALL have port RF_s, output, 1 bit: register-file write-data mux (1 = data memory, 0 = ALU Q).
REQ-010 The block SHALL have ports RF_W_Addr, RF_Ra_Addr and RF_Rb_Addr, outputs, 4 bits each: register-file write, read-A and read-B addresses.
REQ-011 The block SHALL have port RF_W_En, output, 1 bit: register-file write enable.
REQ-012 The block SHALL have port ALU_s0, output, 3 bits: ALU Sel (0 zero, 1 add, 2 sub, 3 pass A, 4 xor, 5 or, 6 and, 7 inc).
REQ-013 The block SHALL have port Halted, output, 1 bit: high in HALT.
REQ-014 The block SHALL have port State, output, 4 bits: current state encoding, for debug.

Function
REQ-015 IR format SHALL be [15:12] opcode; LOAD/STORE use [11:4] D address and [3:0] register; ALU ops use [11:8] Ra, [7:4] Rb, [3:0] Rd.
REQ-016 Opcodes SHALL be: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6 XOR, 7 OR, 8 AND, 9 INC (Ra+1), 10 MOV (pass A).
REQ-017 Opcodes 11-15 SHALL execute as NOOP.
REQ-018 States SHALL be INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, EXEC and HALT.
REQ-019 INIT SHALL clear PC and IR, then go to FETCH.
REQ-020 FETCH SHALL load IR from IR_In, set PC to PC+1 modulo 2^PC_W (so 2^PC_W-1 wraps to 0), then go to DECODE.
REQ-021 DECODE SHALL branch on the opcode to NOOP, STORE, LOAD_A, EXEC or HALT.
REQ-022 NOOP, STORE, LOAD_B and EXEC SHALL each last one cycle, then go to FETCH.
REQ-023 STORE SHALL assert D_Wr=1, D_Addr=IR[11:4] and RF_Ra_Addr=IR[3:0].
REQ-024 LOAD_A SHALL drive D_Addr=IR[11:4] to allow the one-cycle synchronous RAM read, then go to LOAD_B.
REQ-025 LOAD_B SHALL hold D_Addr and assert RF_s=1, RF_W_En=1 and RF_W_Addr=IR[3:0].
REQ-026 EXEC SHALL drive RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], ALU_s0 from the opcode, RF_s=0, RF_W_En=1 and RF_W_Addr=IR[3:0].
REQ-027 HALT SHALL be absorbing: only Reset exits it.
REQ-028 Outside the states named above, D_Wr, RF_W_En, RF_s and ALU_s0 SHALL be 0; address outputs are don't-care but SHALL be driven to 0.
REQ-029 All control outputs SHALL be Moore outputs decoded from State and IR.
REQ-030 Instruction latency SHALL be: NOOP, STORE and ALU ops 3 cycles (FETCH to completion); LOAD 4 cycles.

Reset
REQ-031 Reset SHALL act asynchronously and put the block in INIT with PC=0, IR=0 and all strobes 0, including mid-instruction.
REQ-032 A D_Wr or RF_W_En interrupted by Reset SHALL drop in the same cycle.
REQ-033 On Reset release, the first FETCH SHALL occur one clock after INIT.

Configuration
REQ-034 When macro CTRL_SINGLE_STEP_EN is defined, the block SHALL add input Step (1 bit).
REQ-035 With CTRL_SINGLE_STEP_EN defined, FETCH SHALL hold, with no IR load and no PC increment, until Step=1 on a clock edge.
REQ-036 With CTRL_SINGLE_STEP_EN undefined, the Step port SHALL be absent and FETCH SHALL be unconditional.

Structure
REQ-037 Package ctrl_pkg SHALL hold the state enum, the opcode enum and the ALU-select constants, shared with the ALU bench.
REQ-038 The PC SHALL be a sub-module pc_counter with Clr and Up inputs; IR and the FSM SHALL live in control_unit.

Verification
REQ-039 Bench SHALL cover: Reset, then IR_In=16'h2A03 (LOAD 0xA0 to R3) -> FETCH, DECODE, LOAD_A (D_Addr=A0), LOAD_B (RF_W_En=1, RF_s=1, RF_W_Addr=3), PC=1.
REQ-040 Bench SHALL cover: IR_In=16'h3125 (ADD R1+R2 to R5) -> EXEC with ALU_s0=1, Ra=1, Rb=2, RF_W_Addr=5, RF_s=0.
REQ-041 Bench SHALL cover: IR_In=16'h1F07 (STORE R7 to 0xF0) -> D_Wr=1 for exactly one cycle with D_Addr=F0.
REQ-042 Bench SHALL cover: IR_In=16'h5000 -> Halted=1 and State held for 20 cycles; Reset -> INIT with PC=0.
REQ-043 Bench SHALL cover: 128 NOOP fetches -> PC wraps 127 to 0; opcode 16'hF000 -> NOOP path with no strobes.
REQ-044 Bench SHALL cover: Reset asserted during LOAD_B -> RF_W_En=0 immediately and State=INIT.
